// File: rtl/de_pkg.sv
// Shared encodings and defaults for the drawing-engine port arbiter.
package de_pkg;

    localparam logic [0:0] DE_IDLE  = 1'b0;
    localparam logic [0:0] DE_GRANT = 1'b1;

    localparam int DE_ADDR_W = 18;
    localparam int DE_DATA_W = 32;

    // Byte enables are active-low, so all ones means no byte enabled.
    localparam logic [3:0] DE_NBYTE_NONE = 4'b1111;

endpackage

// File: rtl/de_port_arbiter_rr_pick.sv
// Cyclic priority encoder: first set request at or after rr_ptr, wrapping at N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    int idx;

    // Scan farthest-first so the candidate closest to rr_ptr overwrites the rest.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[IDX_W'(idx)]) begin
                grant = IDX_W'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/de_port_arbiter.sv
// Round-robin arbiter sharing one framestore drawing-engine port among N_REQ drawing units,
// one transfer per grant with a single idle cycle between transfers.
module de_port_arbiter
    import de_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = DE_ADDR_W,
    parameter int DATA_W = DE_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           s_de_req,
    input  logic [N_REQ*ADDR_W-1:0]    s_de_addr,
    input  logic [N_REQ*DATA_W/8-1:0]  s_de_nbyte,
    input  logic [N_REQ-1:0]           s_de_rnw,
    input  logic [N_REQ*DATA_W-1:0]    s_de_w_data,
    output logic [N_REQ-1:0]           s_de_ack,
    output logic [DATA_W-1:0]          s_de_r_data,
    output logic                       m_de_req,
    output logic [ADDR_W-1:0]          m_de_addr,
    output logic [DATA_W/8-1:0]        m_de_nbyte,
    output logic                       m_de_rnw,
    output logic [DATA_W-1:0]          m_de_w_data,
    input  logic                       m_de_ack,
    input  logic [DATA_W-1:0]          m_de_r_data,
    output logic                       busy
);

    localparam int NB_W  = DATA_W / 8;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [0:0]       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             in_grant;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= N_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (s_de_req),
        .rr_ptr (rr_ptr),
        .grant  (pick_idx),
        .valid  (pick_vld)
    );

    assign in_grant    = (state == DE_GRANT);
    assign m_de_req    = in_grant;
    assign busy        = in_grant;
    assign s_de_r_data = m_de_r_data;

    // An owner that abandons its request releases the port without earning a pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DE_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                DE_IDLE: begin
                    if (pick_vld) begin
                        owner <= pick_idx;
                        state <= DE_GRANT;
                    end
                end
                default: begin
                    if (m_de_ack) begin
                        rr_ptr <= next_idx(owner);
                        state  <= DE_IDLE;
                    end else if (!s_de_req[owner]) begin
                        state <= DE_IDLE;
                    end
                end
            endcase
        end
    end

    // Outside GRANT the bus is parked and any framestore ack is swallowed.
    always_comb begin
        m_de_addr   = '0;
        m_de_nbyte  = {NB_W{1'b1}};
        m_de_rnw    = 1'b0;
        m_de_w_data = '0;
        s_de_ack    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (in_grant && owner == IDX_W'(i)) begin
                m_de_addr   = s_de_addr[i*ADDR_W +: ADDR_W];
                m_de_nbyte  = s_de_nbyte[i*NB_W +: NB_W];
                m_de_rnw    = s_de_rnw[i];
                m_de_w_data = s_de_w_data[i*DATA_W +: DATA_W];
                s_de_ack[i] = m_de_ack;
            end
        end
    end

endmodule

// File: tb/tb_de_port_arbiter.sv
// Bench for de_port_arbiter with three requesters: vector table feeding a transfer scoreboard,
// plus hand-written protocol-violation and mid-transfer reset sequences.
module tb_de_port_arbiter;
    import de_pkg::*;

    localparam int N  = 3;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam int NB = DW / 8;

    typedef struct {
        int            unit;
        logic [AW-1:0] addr;
        logic [NB-1:0] nbyte;
        logic          rnw;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            wait_cyc;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_v = '0;
    logic [N*AW-1:0] addr_v = '0;
    logic [N*NB-1:0] nbyte_v = '1;
    logic [N-1:0]    rnw_v = '0;
    logic [N*DW-1:0] wdata_v = '0;
    logic [N-1:0]    s_de_ack;
    logic [DW-1:0]   s_de_r_data;
    logic            m_de_req;
    logic [AW-1:0]   m_de_addr;
    logic [NB-1:0]   m_de_nbyte;
    logic            m_de_rnw;
    logic [DW-1:0]   m_de_w_data;
    logic            m_ack = 1'b0;
    logic [DW-1:0]   m_rdata = '0;
    logic            busy;

    rec_t tbl [13];
    rec_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;

    de_port_arbiter #(
        .N_REQ  (N),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_de_req    (req_v),
        .s_de_addr   (addr_v),
        .s_de_nbyte  (nbyte_v),
        .s_de_rnw    (rnw_v),
        .s_de_w_data (wdata_v),
        .s_de_ack    (s_de_ack),
        .s_de_r_data (s_de_r_data),
        .m_de_req    (m_de_req),
        .m_de_addr   (m_de_addr),
        .m_de_nbyte  (m_de_nbyte),
        .m_de_rnw    (m_de_rnw),
        .m_de_w_data (m_de_w_data),
        .m_de_ack    (m_ack),
        .m_de_r_data (m_rdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(input int u, input logic [AW-1:0] a, input logic [NB-1:0] nb,
                                input logic r, input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                                input int w);
        rec_t x;
        x.unit = u; x.addr = a; x.nbyte = nb; x.rnw = r;
        x.wdata = wd; x.rdata = rd; x.wait_cyc = w;
        return x;
    endfunction

    task automatic set_unit(input rec_t r, input bit push);
        addr_v[r.unit*AW +: AW]  = r.addr;
        nbyte_v[r.unit*NB +: NB] = r.nbyte;
        rnw_v[r.unit]            = r.rnw;
        wdata_v[r.unit*DW +: DW] = r.wdata;
        req_v[r.unit]            = 1'b1;
        if (push) sb.push_back(r);
    endtask

    // Waits for the grant, checks the muxed bus against the scoreboard head, acks, checks the bubble.
    task automatic service();
        rec_t         e;
        logic [N-1:0] oh;
        int           n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_de_req && n < 20);
        check("grant_latency", n, 1);
        if (!m_de_req || sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_or_sb: m_de_req=%0b, sb entries=%0d at %0t", m_de_req, sb.size(), $time);
            return;
        end
        e = sb.pop_front();
        check("busy", busy, 1);
        check("m_addr", m_de_addr, e.addr);
        check("m_nbyte", m_de_nbyte, e.nbyte);
        check("m_rnw", m_de_rnw, e.rnw);
        check("m_wdata", m_de_w_data, e.wdata);
        check("ack_wait", s_de_ack, 0);
        repeat (e.wait_cyc - 1) begin
            @(negedge clk);
            check("hold_req", m_de_req, 1);
            check("ack_wait", s_de_ack, 0);
        end
        @(posedge clk);
        #1;
        m_ack = 1'b1;
        m_rdata = e.rdata;
        @(negedge clk);
        oh = '0;
        oh[e.unit] = 1'b1;
        check("s_ack_onehot", s_de_ack, oh);
        check("s_rdata", s_de_r_data, e.rdata);
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        m_rdata = '0;
        req_v[e.unit] = 1'b0;
        @(negedge clk);
        check("bubble_req", m_de_req, 0);
        check("bubble_ack", s_de_ack, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(0, 18'h00100, 4'b0000, 1'b0, 32'h11111111, 32'h00000000, 1);
        tbl[1]  = mk(1, 18'h00200, 4'b1110, 1'b1, 32'h00000000, 32'hA5A50001, 1);
        tbl[2]  = mk(2, 18'h3FFFF, 4'b0011, 1'b0, 32'hCAFE0002, 32'h00000000, 1);
        tbl[3]  = mk(0, 18'h00101, 4'b0000, 1'b1, 32'h00000000, 32'h5A5A0003, 1);
        tbl[4]  = mk(1, 18'h00201, 4'b1000, 1'b0, 32'h44444444, 32'h00000000, 1);
        tbl[5]  = mk(2, 18'h00000, 4'b0000, 1'b1, 32'h00000000, 32'h12345678, 1);
        tbl[6]  = mk(1, 18'h0012C, 4'b1101, 1'b0, 32'h3C3C3C3C, 32'h00000000, 2);
        tbl[7]  = mk(0, 18'h00055, 4'b0000, 1'b1, 32'h00000000, 32'hDEADBEEF, 1);
        tbl[8]  = mk(1, 18'h2AAAA, 4'b0101, 1'b0, 32'h0BADF00D, 32'h00000000, 1);
        tbl[9]  = mk(2, 18'h01234, 4'b0000, 1'b0, 32'h99999999, 32'h00000000, 1);
        tbl[10] = mk(0, 18'h00777, 4'b0110, 1'b1, 32'h00000000, 32'h87654321, 1);
        tbl[11] = mk(1, 18'h02222, 4'b0000, 1'b0, 32'h2222AAAA, 32'h00000000, 1);
        tbl[12] = mk(0, 18'h03333, 4'b0000, 1'b1, 32'h00000000, 32'h33334444, 3);

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_req", m_de_req, 0);
        check("rst_nbyte", m_de_nbyte, DE_NBYTE_NONE);
        check("rst_ack", s_de_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", m_de_addr, 0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_req", m_de_req, 0);
            check("idle_busy", busy, 0);
            check("idle_nbyte", m_de_nbyte, DE_NBYTE_NONE);
        end

        // All units requesting continuously: grants rotate 0,1,2,0,1,2
        for (int i = 0; i < 3; i++) set_unit(tbl[i], 1'b1);
        for (int k = 0; k < 6; k++) begin
            service();
            if (k + 3 < 6) set_unit(tbl[k+3], 1'b1);
        end

        // Single unit-1 write, ack after 2 cycles
        set_unit(tbl[6], 1'b1);
        service();

        // Unit-0 read with unit 1 also pending; pointer at 2 wraps to 0
        set_unit(tbl[7], 1'b1);
        set_unit(tbl[8], 1'b1);
        service();
        service();

        // Owner drops its request without an ack, then a stray ack arrives in idle
        set_unit(tbl[9], 1'b0);
        @(negedge clk);
        check("viol_grant", m_de_req, 1);
        req_v[2] = 1'b0;
        @(negedge clk);
        check("viol_release", m_de_req, 0);
        check("viol_busy", busy, 0);
        @(posedge clk);
        #1;
        m_ack = 1'b1;
        @(negedge clk);
        check("late_ack_fwd", s_de_ack, 0);
        check("late_ack_req", m_de_req, 0);
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        @(negedge clk);
        set_unit(tbl[9], 1'b1);
        set_unit(tbl[10], 1'b1);
        service();
        service();

        // Reset in the middle of an acked grant
        set_unit(tbl[11], 1'b1);
        service();
        set_unit(tbl[11], 1'b0);
        @(negedge clk);
        check("rst_mid_grant", m_de_req, 1);
        @(posedge clk);
        #1;
        m_ack = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", s_de_ack, 3'b010);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_req", m_de_req, 0);
        check("rst_async_ack", s_de_ack, 0);
        check("rst_async_busy", busy, 0);
        m_ack = 1'b0;
        req_v = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_unit(tbl[12], 1'b1);
        set_unit(tbl[11], 1'b0);
        set_unit(tbl[9], 1'b0);
        service();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
